// File: rtl/core_msg_rx_pkg.sv
// Shared definitions for the scheduler->core message receiver: bus width,
// receiver FSM states and the rule that picks this core's R0 byte.
package core_msg_rx_pkg;

  localparam int SCHED_MSG_BUS_WIDTH = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_R0M,
    RX_R0D,
    RX_LOAD,
    RX_RUN
  } rx_state_t;

  // Each R0 word carries one byte per core, two cores per word, even core in the low byte.
  function automatic int r0_word_index(input int core_id);
    return core_id >> 1;
  endfunction

  function automatic bit r0_byte_high(input int core_id);
    return (core_id % 2) == 1;
  endfunction

endpackage

// File: rtl/core_msg_rx_ibuf.sv
// Instruction buffer: one synchronous write port, one combinational read port.
// No reset; contents are only meaningful up to the current instruction count.
module core_ibuf #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/core_msg_rx.sv
// Core-side receiver for the scheduler message bus: decodes mask / R0 mask / R0 data /
// instruction words, keeps what is addressed to this core and hands off to the datapath.
module core_msg_rx
  import core_msg_rx_pkg::*;
#(
  parameter int CORE_ID     = 0,
  parameter int CORE_NUM    = 16,
  parameter int BUS_TO_CORE = SCHED_MSG_BUS_WIDTH,
  parameter int R0_WORDS    = 8,
  parameter int IBUF_DEPTH  = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BUS_TO_CORE-1:0]        mess_to_core,
  input  logic                          core_mask_loading,
  input  logic                          r0_mask_loading,
  input  logic                          r0_loading,
  input  logic                          if_loading,
  input  logic                          exec_done,
  input  logic [$clog2(IBUF_DEPTH)-1:0] ibuf_rd_addr,
  output logic [BUS_TO_CORE-1:0]        ibuf_rd_data,
  output logic                          core_ready,
  output logic [BUS_TO_CORE-1:0]        r0_value,
  output logic                          prog_start,
  output logic [$clog2(IBUF_DEPTH):0]   instr_count,
  output logic                          proto_err
);

  localparam int AW = $clog2(IBUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(R0_WORDS);
  localparam int SEL_BIT = CORE_ID % CORE_NUM;
  localparam logic [WW-1:0] R0_IDX  = WW'(r0_word_index(CORE_ID));
  localparam logic [WW-1:0] R0_LAST = WW'(R0_WORDS - 1);
  localparam logic [CW-1:0] FULL    = CW'(IBUF_DEPTH);
  localparam bit R0_HI = r0_byte_high(CORE_ID);

  rx_state_t state, state_nxt;
  logic sel, sel_nxt, r0sel, r0sel_nxt, seen, seen_nxt;
  logic [WW-1:0] wcnt, wcnt_nxt;
  logic [BUS_TO_CORE-1:0] r0_value_nxt;
  logic [CW-1:0] instr_count_nxt;
  logic core_ready_nxt, prog_start_nxt, proto_err_nxt;
  logic ibuf_we;
  logic [3:0] strobes;
  logic multi, any_strobe;
  logic [7:0] r0_byte;

  assign strobes    = {core_mask_loading, r0_mask_loading, r0_loading, if_loading};
  assign multi      = $countones(strobes) > 1;
  assign any_strobe = |strobes;
  assign r0_byte    = R0_HI ? mess_to_core[15:8] : mess_to_core[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RX_IDLE;
      sel         <= 1'b0;
      r0sel       <= 1'b0;
      seen        <= 1'b0;
      wcnt        <= '0;
      r0_value    <= '0;
      instr_count <= '0;
      core_ready  <= 1'b1;
      prog_start  <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      r0sel       <= r0sel_nxt;
      seen        <= seen_nxt;
      wcnt        <= wcnt_nxt;
      r0_value    <= r0_value_nxt;
      instr_count <= instr_count_nxt;
      core_ready  <= core_ready_nxt;
      prog_start  <= prog_start_nxt;
      proto_err   <= proto_err_nxt;
    end
  end

  // A word with more than one strobe is unusable; flag it and leave everything else alone.
  always_comb begin
    state_nxt       = state;
    sel_nxt         = sel;
    r0sel_nxt       = r0sel;
    seen_nxt        = seen;
    wcnt_nxt        = wcnt;
    r0_value_nxt    = r0_value;
    instr_count_nxt = instr_count;
    core_ready_nxt  = core_ready;
    prog_start_nxt  = 1'b0;
    proto_err_nxt   = proto_err;
    ibuf_we         = 1'b0;
    if (multi) begin
      proto_err_nxt = 1'b1;
    end else begin
      case (state)
        RX_IDLE: begin
          if (core_mask_loading) begin
            sel_nxt   = mess_to_core[SEL_BIT];
            state_nxt = RX_R0M;
          end
        end
        RX_R0M: begin
          if (r0_mask_loading) begin
            r0sel_nxt = mess_to_core[SEL_BIT];
            wcnt_nxt  = '0;
            state_nxt = RX_R0D;
          end else if (any_strobe) begin
            proto_err_nxt = 1'b1;
            state_nxt     = RX_IDLE;
          end
        end
        RX_R0D: begin
          if (r0_loading) begin
            if (sel && r0sel && wcnt == R0_IDX)
              r0_value_nxt = {{(BUS_TO_CORE-8){1'b0}}, r0_byte};
            wcnt_nxt = wcnt + 1'b1;
            if (wcnt == R0_LAST) begin
              instr_count_nxt = '0;
              seen_nxt        = 1'b0;
              state_nxt       = RX_LOAD;
            end
          end else if (any_strobe) begin
            proto_err_nxt = 1'b1;
            state_nxt     = RX_IDLE;
          end
        end
        RX_LOAD: begin
          if (if_loading) begin
            seen_nxt = 1'b1;
            if (sel) begin
              if (instr_count == FULL) begin
                proto_err_nxt = 1'b1;
              end else begin
                ibuf_we         = 1'b1;
                instr_count_nxt = instr_count + 1'b1;
              end
            end
          end else if (seen || core_mask_loading) begin
            // A new mask here also ends the program; an unselected core decodes it at once.
            if (sel) begin
              prog_start_nxt = 1'b1;
              core_ready_nxt = 1'b0;
              state_nxt      = RX_RUN;
            end else if (core_mask_loading) begin
              sel_nxt   = mess_to_core[SEL_BIT];
              state_nxt = RX_R0M;
            end else begin
              state_nxt = RX_IDLE;
            end
          end
        end
        RX_RUN: begin
          if (exec_done) begin
            core_ready_nxt = 1'b1;
            state_nxt      = RX_IDLE;
          end
        end
        default: state_nxt = RX_IDLE;
      endcase
    end
  end

  core_ibuf #(
    .DEPTH (IBUF_DEPTH),
    .WIDTH (BUS_TO_CORE),
    .ADDR_W(AW)
  ) u_ibuf (
    .clk    (clk),
    .we     (ibuf_we),
    .wr_addr(instr_count[AW-1:0]),
    .wr_data(mess_to_core),
    .rd_addr(ibuf_rd_addr),
    .rd_data(ibuf_rd_data)
  );

endmodule

// File: tb/tb_core_msg_rx.sv
// Self-checking bench for core_msg_rx (CORE_ID=3): directed message streams, a scoreboard
// of expected program starts, and direct checks of buffer and status outputs.
module tb_core_msg_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mess_to_core;
  logic        core_mask_loading, r0_mask_loading, r0_loading, if_loading;
  logic        exec_done;
  logic [5:0]  ibuf_rd_addr;
  logic [15:0] ibuf_rd_data;
  logic        core_ready;
  logic [15:0] r0_value;
  logic        prog_start;
  logic [6:0]  instr_count;
  logic        proto_err;

  typedef struct {
    logic [15:0] r0;
    logic [6:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses = 0;
  int exp_pulses = 0;

  core_msg_rx #(.CORE_ID(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .mess_to_core     (mess_to_core),
    .core_mask_loading(core_mask_loading),
    .r0_mask_loading  (r0_mask_loading),
    .r0_loading       (r0_loading),
    .if_loading       (if_loading),
    .exec_done        (exec_done),
    .ibuf_rd_addr     (ibuf_rd_addr),
    .ibuf_rd_data     (ibuf_rd_data),
    .core_ready       (core_ready),
    .r0_value         (r0_value),
    .prog_start       (prog_start),
    .instr_count      (instr_count),
    .proto_err        (proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Kind: 0 none, 1 core mask, 2 r0 mask, 3 r0 data, 4 instruction, 5 r0 data + instruction.
  task automatic applyStimulus(input int kind, input logic [15:0] word);
    @(negedge clk);
    mess_to_core      = word;
    core_mask_loading = (kind == 1);
    r0_mask_loading   = (kind == 2);
    r0_loading        = (kind == 3) || (kind == 5);
    if_loading        = (kind == 4) || (kind == 5);
  endtask

  task automatic send_task(input logic [15:0] mask, input logic [15:0] r0mask,
                           input logic [15:0] r0base, input int n, input logic [15:0] ibase,
                           input bit expect_start, input logic [15:0] exp_r0,
                           input logic [6:0] exp_cnt);
    applyStimulus(1, mask);
    applyStimulus(2, r0mask);
    for (int k = 0; k < 8; k++) applyStimulus(3, 16'(r0base + k));
    for (int i = 0; i < n; i++) applyStimulus(4, 16'(ibase + i));
    if (expect_start) begin
      exp_q.push_back('{exp_r0, exp_cnt, cyc + 2});
      exp_pulses++;
    end
    applyStimulus(0, 16'h0000);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_exec_done();
    @(negedge clk);
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    checkOutput("core_ready_after_exec_done", 32'(core_ready), 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_ibuf(input string name, input logic [5:0] addr, input logic [15:0] exp);
    ibuf_rd_addr = addr;
    #1;
    checkOutput(name, 32'(ibuf_rd_data), 32'(exp));
  endtask

  // Monitor: every prog_start pulse must match the oldest expected program start.
  always @(negedge clk) begin
    if (!reset && prog_start) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_prog_start: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("start_r0_value", 32'(r0_value), 32'(e.r0));
        checkOutput("start_instr_count", 32'(instr_count), 32'(e.cnt));
        checkOutput("start_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    reset = 1'b1;
    mess_to_core = '0;
    core_mask_loading = 1'b0;
    r0_mask_loading = 1'b0;
    r0_loading = 1'b0;
    if_loading = 1'b0;
    exec_done = 1'b0;
    ibuf_rd_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_core_ready", 32'(core_ready), 32'd1);
    checkOutput("reset_r0_value", 32'(r0_value), 32'd0);
    checkOutput("reset_prog_start", 32'(prog_start), 32'd0);
    checkOutput("reset_instr_count", 32'(instr_count), 32'd0);
    checkOutput("reset_proto_err", 32'(proto_err), 32'd0);

    $display("[TB] selected task, 16 instructions");
    send_task(16'h0008, 16'h0008, 16'h1100, 16, 16'hA000, 1'b1, 16'h0011, 7'd16);
    checkOutput("t1_core_ready", 32'(core_ready), 32'd0);
    checkOutput("t1_r0_value", 32'(r0_value), 32'h0011);
    checkOutput("t1_instr_count", 32'(instr_count), 32'd16);
    checkOutput("t1_proto_err", 32'(proto_err), 32'd0);
    check_ibuf("t1_ibuf5", 6'd5, 16'hA005);
    checkOutput("t1_core_ready_held", 32'(core_ready), 32'd0);
    pulse_exec_done();

    $display("[TB] task for another core");
    pulse_reset();
    send_task(16'h0004, 16'h0008, 16'h1100, 16, 16'hA000, 1'b0, 16'h0000, 7'd0);
    checkOutput("t2_r0_value", 32'(r0_value), 32'd0);
    checkOutput("t2_core_ready", 32'(core_ready), 32'd1);
    checkOutput("t2_instr_count", 32'(instr_count), 32'd0);
    checkOutput("t2_no_start", 32'(pulses), 32'(exp_pulses));

    $display("[TB] R0 mask clear keeps previous R0");
    send_task(16'h0008, 16'h0008, 16'h4200, 2, 16'hB000, 1'b1, 16'h0042, 7'd2);
    pulse_exec_done();
    send_task(16'h0008, 16'h0000, 16'h7700, 3, 16'hC000, 1'b1, 16'h0042, 7'd3);
    checkOutput("t3_r0_value", 32'(r0_value), 32'h0042);
    checkOutput("t3_core_ready", 32'(core_ready), 32'd0);
    pulse_exec_done();

    $display("[TB] double strobe inside R0 data");
    applyStimulus(1, 16'h0008);
    applyStimulus(2, 16'h0008);
    for (int k = 0; k < 3; k++) applyStimulus(3, 16'(16'h2200 + k));
    applyStimulus(5, 16'hFFFF);
    applyStimulus(3, 16'h2203);
    checkOutput("t4_proto_err", 32'(proto_err), 32'd1);
    for (int k = 4; k < 8; k++) applyStimulus(3, 16'(16'h2200 + k));
    for (int i = 0; i < 4; i++) applyStimulus(4, 16'(16'hD000 + i));
    exp_q.push_back('{16'h0022, 7'd4, cyc + 2});
    exp_pulses++;
    applyStimulus(0, 16'h0000);
    repeat (3) @(negedge clk);
    check_ibuf("t4_ibuf3", 6'd3, 16'hD003);
    checkOutput("t4_core_ready", 32'(core_ready), 32'd0);
    pulse_exec_done();

    $display("[TB] buffer overflow");
    pulse_reset();
    send_task(16'h0008, 16'h0008, 16'h3300, 65, 16'hA000, 1'b1, 16'h0033, 7'd64);
    checkOutput("t5_instr_count", 32'(instr_count), 32'd64);
    checkOutput("t5_proto_err", 32'(proto_err), 32'd1);
    check_ibuf("t5_ibuf63", 6'd63, 16'hA03F);
    check_ibuf("t5_ibuf0", 6'd0, 16'hA000);
    pulse_exec_done();

    $display("[TB] reset in the middle of R0 data");
    applyStimulus(1, 16'h0008);
    applyStimulus(2, 16'h0008);
    for (int k = 0; k < 4; k++) applyStimulus(3, 16'(16'h5500 + k));
    applyStimulus(0, 16'h0000);
    checkOutput("t6_r0_before_reset", 32'(r0_value), 32'h0055);
    checkOutput("t6_count_before_reset", 32'(instr_count), 32'd64);
    reset = 1'b1;
    #1;
    checkOutput("t6_async_core_ready", 32'(core_ready), 32'd1);
    checkOutput("t6_async_instr_count", 32'(instr_count), 32'd0);
    checkOutput("t6_async_r0_value", 32'(r0_value), 32'd0);
    checkOutput("t6_async_proto_err", 32'(proto_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("total_prog_starts", 32'(pulses), 32'(exp_pulses));
    checkOutput("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
